// File: rtl/mcdt_pkg.sv
// ============================================================================
// mcdt_pkg : channel count, id type and default sizes shared by mcdt blocks
// Revision : 1.0
// ============================================================================
`default_nettype none

package mcdt_pkg;

   localparam int NUM_CH = 3;

   typedef logic [1:0] ch_id_t;

   localparam ch_id_t ID_ILLEGAL = 2'd3;

   localparam int DEF_DW    = 32;
   localparam int DEF_DEPTH = 32;

endpackage : mcdt_pkg

`default_nettype wire

// File: rtl/mcdt_rx_fifo.sv
// ============================================================================
// mcdt_rx_fifo : show-ahead synchronous FIFO, one per receive channel
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mcdt_rx_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 32,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          do_push, do_pop;

   // A push into a full buffer is legal only when a pop frees the slot this cycle.
   always_comb begin
      do_pop   = pop_i & (count_q != '0);
      do_push  = push_i & ((count_q != CW'(DEPTH)) | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;

endmodule : mcdt_rx_fifo

`default_nettype wire

// File: rtl/mcdt_demux.sv
// ============================================================================
// mcdt_demux : splits the multiplexed mcdt stream into three buffered channels
// Revision   : 1.0
// ============================================================================
`default_nettype none

module mcdt_demux
   import mcdt_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [DW-1:0] mcdt_data_i,
   input  logic          mcdt_val_i,
   input  ch_id_t        mcdt_id_i,
   output logic [DW-1:0] ch0_data_o,
   output logic          ch0_valid_o,
   input  logic          ch0_ready_i,
   output logic [CW-1:0] ch0_count_o,
   output logic [DW-1:0] ch1_data_o,
   output logic          ch1_valid_o,
   input  logic          ch1_ready_i,
   output logic [CW-1:0] ch1_count_o,
   output logic [DW-1:0] ch2_data_o,
   output logic          ch2_valid_o,
   input  logic          ch2_ready_i,
   output logic [CW-1:0] ch2_count_o,
   output logic [2:0]    ovf_o,
   output logic          bad_id_o,
   output logic [15:0]   drop_cnt_o,
   input  logic          clr_i
);

   logic [NUM_CH-1:0] ready, hit, push, pop, full, empty, drop_full;
   logic [DW-1:0]     rdata [NUM_CH];
   logic [CW-1:0]     count [NUM_CH];
   logic              bad_hit, drop_any;

   logic [2:0]  ovf_q,      ovf_d;
   logic        bad_id_q,   bad_id_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   assign ready = {ch2_ready_i, ch1_ready_i, ch0_ready_i};

   always_comb begin
      hit       = '0;
      push      = '0;
      pop       = '0;
      drop_full = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i]       = mcdt_val_i & (mcdt_id_i == ch_id_t'(i));
         pop[i]       = ready[i] & ~empty[i];
         push[i]      = hit[i] & (~full[i] | pop[i]);
         drop_full[i] = hit[i] & full[i] & ~pop[i];
      end
      bad_hit  = mcdt_val_i & (mcdt_id_i == ID_ILLEGAL);
      drop_any = bad_hit | (|drop_full);
   end

   generate
      for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
         mcdt_rx_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .CW    (CW)
         ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[n]),
            .wdata_i (mcdt_data_i),
            .pop_i   (pop[n]),
            .rdata_o (rdata[n]),
            .empty_o (empty[n]),
            .full_o  (full[n]),
            .count_o (count[n])
         );
      end
   endgenerate

   // Clear wins over a concurrent drop, so that drop is lost from the statistics.
   always_comb begin
      ovf_d      = ovf_q | drop_full;
      bad_id_d   = bad_id_q | bad_hit;
      drop_cnt_d = drop_cnt_q;
      if (drop_any && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
      if (clr_i) begin
         ovf_d      = '0;
         bad_id_d   = 1'b0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_q      <= '0;
         bad_id_q   <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         ovf_q      <= ovf_d;
         bad_id_q   <= bad_id_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ch0_data_o  = rdata[0];
   assign ch1_data_o  = rdata[1];
   assign ch2_data_o  = rdata[2];
   assign ch0_valid_o = ~empty[0];
   assign ch1_valid_o = ~empty[1];
   assign ch2_valid_o = ~empty[2];
   assign ch0_count_o = count[0];
   assign ch1_count_o = count[1];
   assign ch2_count_o = count[2];
   assign ovf_o       = ovf_q;
   assign bad_id_o    = bad_id_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule : mcdt_demux

`default_nettype wire

// File: tb/tb_mcdt_demux.sv
// ============================================================================
// tb_mcdt_demux : directed self-checking bench for mcdt_demux
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_mcdt_demux;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int CW    = 6;

   logic          clk = 1'b0;
   logic          rst_i, clr_i, mcdt_val_i;
   logic [DW-1:0] mcdt_data_i;
   logic [1:0]    mcdt_id_i;
   logic          ch0_ready_i, ch1_ready_i, ch2_ready_i;
   logic [DW-1:0] ch0_data_o, ch1_data_o, ch2_data_o;
   logic          ch0_valid_o, ch1_valid_o, ch2_valid_o;
   logic [CW-1:0] ch0_count_o, ch1_count_o, ch2_count_o;
   logic [2:0]    ovf_o;
   logic          bad_id_o;
   logic [15:0]   drop_cnt_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mcdt_demux #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .mcdt_data_i (mcdt_data_i),
      .mcdt_val_i  (mcdt_val_i),
      .mcdt_id_i   (mcdt_id_i),
      .ch0_data_o  (ch0_data_o),
      .ch0_valid_o (ch0_valid_o),
      .ch0_ready_i (ch0_ready_i),
      .ch0_count_o (ch0_count_o),
      .ch1_data_o  (ch1_data_o),
      .ch1_valid_o (ch1_valid_o),
      .ch1_ready_i (ch1_ready_i),
      .ch1_count_o (ch1_count_o),
      .ch2_data_o  (ch2_data_o),
      .ch2_valid_o (ch2_valid_o),
      .ch2_ready_i (ch2_ready_i),
      .ch2_count_o (ch2_count_o),
      .ovf_o       (ovf_o),
      .bad_id_o    (bad_id_o),
      .drop_cnt_o  (drop_cnt_o),
      .clr_i       (clr_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic valid_of(input int c);
      case (c)
         0:       return ch0_valid_o;
         1:       return ch1_valid_o;
         default: return ch2_valid_o;
      endcase
   endfunction

   function automatic logic [DW-1:0] data_of(input int c);
      case (c)
         0:       return ch0_data_o;
         1:       return ch1_data_o;
         default: return ch2_data_o;
      endcase
   endfunction

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_i = 1'b1; clr_i = 1'b0; mcdt_val_i = 1'b0; mcdt_data_i = '0; mcdt_id_i = 2'd0;
      ch0_ready_i = 1'b1; ch1_ready_i = 1'b1; ch2_ready_i = 1'b1;
      repeat (10) step();
      rst_i = 1'b0;

      chk("reset_valid", {29'd0, ch2_valid_o, ch1_valid_o, ch0_valid_o}, 32'd0);
      chk("reset_count0", ch0_count_o, 32'd0);
      chk("reset_count1", ch1_count_o, 32'd0);
      chk("reset_count2", ch2_count_o, 32'd0);
      chk("reset_ovf", ovf_o, 32'd0);
      chk("reset_bad", bad_id_o, 32'd0);
      chk("reset_drop", drop_cnt_o, 32'd0);

      // Basic routing: one word every two cycles, all consumers ready.
      for (int j = 0; j < 100; j++) begin
         for (int c = 0; c < 3; c++) begin
            mcdt_val_i = 1'b1; mcdt_id_i = 2'(c); mcdt_data_i = 32'(c * 'h1000 + j);
            step();
            mcdt_val_i = 1'b0;
            chk("route_valid", valid_of(c), 32'd1);
            chk("route_data", data_of(c), 32'(c * 'h1000 + j));
            step();
            chk("route_popped", valid_of(c), 32'd0);
         end
      end
      chk("route_drop", drop_cnt_o, 32'd0);
      chk("route_ovf", ovf_o, 32'd0);
      chk("route_bad", bad_id_o, 32'd0);

      // Overflow on ch0.
      ch0_ready_i = 1'b0;
      for (int j = 0; j < 40; j++) begin
         mcdt_val_i = 1'b1; mcdt_id_i = 2'd0; mcdt_data_i = 32'(j);
         step();
         if (j == 31) begin
            chk("ovf_full_count", ch0_count_o, 32'd32);
            chk("ovf_not_yet", ovf_o, 32'd0);
         end
         if (j == 32) chk("ovf_first_drop", ovf_o, 32'd1);
      end
      mcdt_val_i = 1'b0;
      chk("ovf_count", ch0_count_o, 32'd32);
      chk("ovf_flags", ovf_o, 32'b001);
      chk("ovf_drop", drop_cnt_o, 32'd8);
      ch0_ready_i = 1'b1;
      for (int i = 0; i < 32; i++) begin
         chk("ovf_pop_valid", ch0_valid_o, 32'd1);
         chk("ovf_pop_data", ch0_data_o, 32'(i));
         step();
      end
      chk("ovf_drained", ch0_count_o, 32'd0);
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      chk("clr_ovf", ovf_o, 32'd0);
      chk("clr_drop", drop_cnt_o, 32'd0);

      // Full ch1 with simultaneous push and pop.
      ch1_ready_i = 1'b0;
      for (int j = 0; j < 32; j++) begin
         mcdt_val_i = 1'b1; mcdt_id_i = 2'd1; mcdt_data_i = 32'('h1100 + j);
         step();
      end
      chk("fullpp_count", ch1_count_o, 32'd32);
      for (int j = 0; j < 10; j++) begin
         ch1_ready_i = 1'b1;
         mcdt_val_i = 1'b1; mcdt_id_i = 2'd1; mcdt_data_i = 32'('h1100 + 32 + j);
         chk("fullpp_hold", ch1_count_o, 32'd32);
         chk("fullpp_head", ch1_data_o, 32'('h1100 + j));
         step();
      end
      mcdt_val_i = 1'b0;
      chk("fullpp_count_after", ch1_count_o, 32'd32);
      for (int i = 10; i < 42; i++) begin
         chk("fullpp_drain", ch1_data_o, 32'('h1100 + i));
         step();
      end
      chk("fullpp_empty", ch1_count_o, 32'd0);
      chk("fullpp_drop", drop_cnt_o, 32'd0);
      chk("fullpp_ovf", ovf_o, 32'd0);

      // Illegal id.
      mcdt_val_i = 1'b1; mcdt_id_i = 2'd3; mcdt_data_i = 32'hDEAD;
      step();
      mcdt_val_i = 1'b0;
      chk("bad_flag", bad_id_o, 32'd1);
      chk("bad_drop", drop_cnt_o, 32'd1);
      chk("bad_no_valid", {29'd0, ch2_valid_o, ch1_valid_o, ch0_valid_o}, 32'd0);

      // Saturation then clear colliding with a drop.
      mcdt_val_i = 1'b1; mcdt_id_i = 2'd3;
      repeat (65540) step();
      chk("sat_drop", drop_cnt_o, 32'hFFFF);
      clr_i = 1'b1;
      step();
      clr_i = 1'b0; mcdt_val_i = 1'b0;
      chk("clr_sat_drop", drop_cnt_o, 32'd0);
      chk("clr_sat_bad", bad_id_o, 32'd0);
      chk("clr_sat_ovf", ovf_o, 32'd0);
      step();
      chk("clr_sat_hold", drop_cnt_o, 32'd0);

      // Reset mid-stream with ch2 holding 5 words.
      ch2_ready_i = 1'b0;
      for (int j = 0; j < 5; j++) begin
         mcdt_val_i = 1'b1; mcdt_id_i = 2'd2; mcdt_data_i = 32'('h2200 + j);
         step();
      end
      chk("mid_count", ch2_count_o, 32'd5);
      rst_i = 1'b1; clr_i = 1'b1; ch2_ready_i = 1'b1;
      mcdt_val_i = 1'b1; mcdt_id_i = 2'd2; mcdt_data_i = 32'h2FFF;
      step();
      rst_i = 1'b0; clr_i = 1'b0; ch2_ready_i = 1'b0; mcdt_val_i = 1'b0;
      chk("rst_count", ch2_count_o, 32'd0);
      chk("rst_valid", ch2_valid_o, 32'd0);
      mcdt_val_i = 1'b1; mcdt_id_i = 2'd2; mcdt_data_i = 32'h2ABC;
      step();
      mcdt_val_i = 1'b0;
      chk("post_rst_valid", ch2_valid_o, 32'd1);
      chk("post_rst_count", ch2_count_o, 32'd1);
      chk("post_rst_data", ch2_data_o, 32'h2ABC);
      ch2_ready_i = 1'b1;
      step();
      chk("post_rst_pop", ch2_count_o, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mcdt_demux

`default_nettype wire
